// File: rtl/spike_window_decoder_pkg.sv
// Shared definitions for the spike window decoder: default sizing and FSM states.
package spike_window_decoder_pkg;

  localparam int unsigned N_DEF       = 7;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned WIN_LEN_DEF = 200;
  localparam int unsigned RATE_TH_DEF = 3;

  // Window timer width; WIN_LEN is always below 2**16.
  localparam int unsigned WIN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/spike_window_decoder_sat_counter.sv
// Per-neuron saturating spike counter. o_count_nxt is the count including the
// current cycle's sample, so the parent can latch final results on the last edge.
module spike_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count_nxt,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;
  // An increment attempted while already at the maximum.
  assign o_sat    = i_en & i_inc & w_at_max;

  // Next count: add the sample unless already saturated.
  always_comb begin
    o_count_nxt = r_count;
    if (i_en && i_inc && !w_at_max) begin
      o_count_nxt = r_count + 1'b1;
    end
  end

  // Count register: cleared at window start/abort, otherwise tracks the next value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_nxt;
    end
  end

endmodule

// File: rtl/spike_window_decoder.sv
// Hopfield readout stage: counts spikes per neuron over a fixed window, thresholds
// the counts into a recalled pattern and offers it over a valid/ready handshake.
module spike_window_decoder
  import spike_window_decoder_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned RATE_TH = RATE_TH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     spikes,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [N-1:0]     pattern_out,
  output logic [CNT_W-1:0] peak_count,
  output logic             sat_flag
);

  localparam logic [WIN_W-1:0] LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] TH   = CNT_W'(RATE_TH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIN_W-1:0] r_win_cnt;
  logic             r_busy;
  logic             r_valid;
  logic [N-1:0]     r_pattern;
  logic [CNT_W-1:0] r_peak;
  logic             r_sat;

  logic             w_start_win;
  logic             w_clr;
  logic             w_en;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_nxt [N];
  logic [N-1:0]     w_sat;
  logic [N-1:0]     w_pattern;
  logic [CNT_W-1:0] w_peak;

  for (genvar g = 0; g < N; g++) begin : g_cnt
    spike_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_clr       (w_clr),
      .i_en        (w_en),
      .i_inc       (spikes[g]),
      .o_count_nxt (w_cnt_nxt[g]),
      .o_sat       (w_sat[g])
    );
  end

  // Next-state and control strobes; abort outranks start and the handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_start_win = 1'b0;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!abort && start) begin
          w_state_nxt = ST_COUNT;
          w_start_win = 1'b1;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else begin
          w_en = 1'b1;
          if (r_win_cnt == LAST) begin
            w_last      = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_clr       = 1'b1;
        end else if (out_ready) begin
          if (start) begin
            w_state_nxt = ST_COUNT;
            w_start_win = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_start_win) begin
      w_clr = 1'b1;
    end
  end

  // Threshold and max reduction over the counts including the current sample.
  always_comb begin
    w_pattern = '0;
    w_peak    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_pattern[i] = (w_cnt_nxt[i] >= TH);
      if (w_cnt_nxt[i] > w_peak) begin
        w_peak = w_cnt_nxt[i];
      end
    end
  end

  // State register with busy/valid registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_COUNT);
      r_valid <= (w_state_nxt == ST_HOLD);
    end
  end

  // Window timer: restarted at window start, advanced on every sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_cnt <= '0;
    end else if (w_clr) begin
      r_win_cnt <= '0;
    end else if (w_en) begin
      r_win_cnt <= r_win_cnt + 1'b1;
    end
  end

  // Result registers latched on the last-sample edge; sat flag sticky per window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= '0;
      r_peak    <= '0;
      r_sat     <= 1'b0;
    end else begin
      if (w_last) begin
        r_pattern <= w_pattern;
        r_peak    <= w_peak;
      end
      if (w_start_win) begin
        r_sat <= 1'b0;
      end else if (|w_sat) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign busy        = r_busy;
  assign out_valid   = r_valid;
  assign pattern_out = r_pattern;
  assign peak_count  = r_peak;
  assign sat_flag    = r_sat;

endmodule
